// File: rtl/lpce_pkg.sv
// Shared types and helpers for the LPCE transmit path.
package lpce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_PARITY
    } lpce_tx_state_t;

    localparam logic [7:0]  LPCE_SYNC_PAT = 8'hB8;
    localparam int unsigned LPCE_PAR_W    = 256;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_par(input logic [LPCE_PAR_W-1:0] v);
        return ^v;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lpce_sync_fifo.sv
// Single-clock FIFO with registered full/empty; the head word is visible on o_rd_data with no read latency.
module lpce_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic [W-1:0]                 i_wr_data,
    input  logic                         i_rd_en,
    output logic [W-1:0]                 o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count_nxt,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [NW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          w_push;
    logic          w_pop;
    logic [NW-1:0] w_count_nxt;

    // Full comes from the registered count, so a write while full is dropped even if a pop coincides.
    always_comb begin
        w_push      = i_wr_en & ~r_full;
        w_pop       = i_rd_en & ~r_empty;
        w_count_nxt = r_count + NW'(w_push) - NW'(w_pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == NW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_data   = r_mem[r_rptr];
    assign o_count_nxt = w_count_nxt;
    assign o_full      = r_full;
    assign o_empty     = r_empty;

endmodule

// File: rtl/lpce_lane_tx.sv
// Multi-lane LPCE transmit framer: FIFO-buffered words striped across LANES serial lanes,
// each lane frame being SYNC header, payload MSB-first, then one even-parity bit.
module lpce_lane_tx
    import lpce_pkg::*;
#(
    parameter int unsigned       LANES      = 4,
    parameter int unsigned       WORD_W     = 128,
    parameter int unsigned       DEPTH      = 16,
    parameter int unsigned       SYNC_W     = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_W'(LPCE_SYNC_PAT),
    parameter int unsigned       SYNC_EVERY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              WR_EN,
    input  logic [WORD_W-1:0] WR_DATA,
    output logic              WR_FULL,
    output logic              OVF,
    input  logic              OVF_CLR,
    output logic [LANES-1:0]  LPCE_DATo,
    output logic              LPCE_FRM,
    output logic              BUSY
);

    localparam int unsigned LW = WORD_W / LANES;
    localparam int unsigned CW = cnt_width(SYNC_W, LW);
    localparam int unsigned NW = $clog2(DEPTH+1);

    lpce_tx_state_t    r_state;
    logic [CW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_shreg;
    logic [SYNC_W-1:0] r_sync;
    logic [LANES-1:0]  r_dato;
    logic              r_frm;
    logic              r_busy;
    logic              r_ovf;

    logic [WORD_W-1:0] w_head;
    logic [NW-1:0]     w_count_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_more;
    logic              w_sync_last;
    logic              w_pay_last;
    logic              w_pop;
    logic              w_active_nxt;
    logic [LW-1:0]     w_slice;
    logic [WORD_W-1:0] w_rot;
    logic [SYNC_W-1:0] w_sync_rot;
    logic [LANES-1:0]  w_lane_msb;
    logic [LANES-1:0]  w_lane_par;
    logic [LANES-1:0]  w_dato_nxt;

    lpce_sync_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_wr_en     (WR_EN),
        .i_wr_data   (WR_DATA),
        .i_rd_en     (w_pop),
        .o_rd_data   (w_head),
        .o_count_nxt (w_count_nxt),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_more       = ENABLE & ~w_empty;
        w_sync_last  = (r_state == ST_SYNC)    && (r_cnt == CW'(SYNC_W-1));
        w_pay_last   = (r_state == ST_PAYLOAD) && (r_cnt == CW'(LW-1));
        w_pop        = w_sync_last || ((r_state == ST_PARITY) && w_more && (SYNC_EVERY == 0));
        w_active_nxt = ((r_state == ST_IDLE) || (r_state == ST_PARITY)) ? w_more : 1'b1;
        w_sync_rot   = (r_sync << 1) | (r_sync >> (SYNC_W-1));
    end

    // Slices and header rotate a full turn per frame, so parity is taken from the restored slice.
    always_comb begin
        w_slice    = '0;
        w_rot      = '0;
        w_lane_msb = '0;
        w_lane_par = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_slice             = r_shreg[i*LW +: LW];
            w_lane_msb[i]       = w_slice[LW-1];
            w_lane_par[i]       = even_par(LPCE_PAR_W'(w_slice));
            w_rot[i*LW +: LW]   = (w_slice << 1) | (w_slice >> (LW-1));
        end
    end

    always_comb begin
        case (r_state)
            ST_SYNC:    w_dato_nxt = {LANES{r_sync[SYNC_W-1]}};
            ST_PAYLOAD: w_dato_nxt = w_lane_msb;
            ST_PARITY:  w_dato_nxt = w_lane_par;
            default:    w_dato_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_sync  <= SYNC_PAT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_more) begin
                        r_state <= ST_SYNC;
                        r_cnt   <= '0;
                    end
                end
                ST_SYNC: begin
                    r_sync <= w_sync_rot;
                    if (w_sync_last) begin
                        r_state <= ST_PAYLOAD;
                        r_cnt   <= '0;
                        r_shreg <= w_head;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_PAYLOAD: begin
                    r_shreg <= w_rot;
                    if (w_pay_last) begin
                        r_state <= ST_PARITY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    r_cnt <= '0;
                    if (!w_more) begin
                        r_state <= ST_IDLE;
                    end else if (SYNC_EVERY == 0) begin
                        r_state <= ST_PAYLOAD;
                        r_shreg <= w_head;
                    end else begin
                        r_state <= ST_SYNC;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Serial outputs trail the FSM state by one register stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dato <= '0;
            r_frm  <= 1'b0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_dato <= w_dato_nxt;
            r_frm  <= (r_state != ST_IDLE);
            r_busy <= w_active_nxt || (w_count_nxt != '0);
            if (WR_EN && w_full)
                r_ovf <= 1'b1;
            else if (OVF_CLR)
                r_ovf <= 1'b0;
        end
    end

    assign LPCE_DATo = r_dato;
    assign LPCE_FRM  = r_frm;
    assign BUSY      = r_busy;
    assign OVF       = r_ovf;
    assign WR_FULL   = w_full;

endmodule

// File: tb/tb_lpce_lane_tx.sv
// Scoreboard bench: two framers (header per word / header per burst) fed identical stimulus.
module tb_lpce_lane_tx;

    localparam logic [7:0] PAT = 8'hB8;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            ENABLE = 1'b0;
    logic            WR_EN = 1'b0;
    logic            OVF_CLR = 1'b0;
    logic [15:0]     WR_DATA = '0;
    logic [1:0]      full;
    logic [1:0]      ovf;
    logic [1:0]      frm;
    logic [1:0]      busy;
    logic [1:0][3:0] dato;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    lpce_lane_tx #(.LANES(4), .WORD_W(16), .DEPTH(16), .SYNC_W(8), .SYNC_PAT(8'hB8), .SYNC_EVERY(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .WR_FULL(full[0]), .OVF(ovf[0]), .OVF_CLR(OVF_CLR),
        .LPCE_DATo(dato[0]), .LPCE_FRM(frm[0]), .BUSY(busy[0])
    );

    lpce_lane_tx #(.LANES(4), .WORD_W(16), .DEPTH(16), .SYNC_W(8), .SYNC_PAT(8'hB8), .SYNC_EVERY(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .WR_FULL(full[1]), .OVF(ovf[1]), .OVF_CLR(OVF_CLR),
        .LPCE_DATo(dato[1]), .LPCE_FRM(frm[1]), .BUSY(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor k expands each queued word into its frame and compares lane bits while FRM is high.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        localparam bit HDR_EACH = (k == 1);
        logic [15:0] exp_words[$];
        logic [3:0]  exp_bits[$];
        logic        prev = 1'b0;
        int          run = 0;
        int          last_run = 0;
        int          words_started = 0;
        int          frm_cycles = 0;

        always @(negedge CLK) begin
            logic [15:0] w;
            logic [3:0]  v;
            logic [3:0]  e;
            logic [7:0]  pat;
            if (RST) begin
                exp_bits.delete();
                prev = 1'b0;
                run  = 0;
            end else begin
                if (frm[k]) begin
                    run++;
                    frm_cycles++;
                    if (exp_bits.size() == 0) begin
                        if (exp_words.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame dut%0d: lanes=%0h with no word queued, expected no frame", k, dato[k]);
                        end else begin
                            w = exp_words.pop_front();
                            words_started++;
                            pat = PAT;
                            if (!prev || HDR_EACH)
                                for (int b = 0; b < 8; b++) exp_bits.push_back({4{pat[7-b]}});
                            for (int j = 0; j < 4; j++) begin
                                for (int i = 0; i < 4; i++) v[i] = w[i*4 + 3 - j];
                                exp_bits.push_back(v);
                            end
                            for (int i = 0; i < 4; i++) v[i] = ^w[i*4 +: 4];
                            exp_bits.push_back(v);
                        end
                    end
                    if (exp_bits.size() != 0) begin
                        e = exp_bits.pop_front();
                        chk($sformatf("lane_bits_dut%0d", k), 32'(dato[k]), 32'(e));
                    end
                end else begin
                    if (prev) last_run = run;
                    run = 0;
                    if (exp_bits.size() != 0) begin
                        checks++;
                        errors++;
                        $display("FAIL truncated_frame dut%0d: %0d bits missing, expected 0", k, exp_bits.size());
                        exp_bits.delete();
                    end
                end
                prev = frm[k];
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        g_mon[0].exp_words.push_back(w);
        g_mon[1].exp_words.push_back(w);
    endtask

    task automatic write_word(input logic [15:0] w, input bit accept);
        WR_EN   = 1'b1;
        WR_DATA = w;
        if (accept) push_word(w);
        tick();
        WR_EN   = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy != 2'b00 || frm != 2'b00) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_within_bound", 32'(n < bound), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int s0;
        int s1;
        int f0;
        int f1;

        // Reset state
        repeat (3) tick();
        chk("rst_dato", 32'(dato), 0);
        chk("rst_frm", 32'(frm), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        RST = 1'b0;
        tick();

        // Single word: latency, 13-cycle frame
        ENABLE = 1'b1;
        write_word(16'hA5C7, 1'b1);
        chk("busy_after_write", 32'(busy), 3);
        chk("frm_lat_t0", 32'(frm), 0);
        tick();
        chk("frm_lat_t1", 32'(frm), 0);
        tick();
        chk("frm_lat_t2", 32'(frm), 3);
        chk("first_sync_bit", 32'(dato), 32'h0000_00FF);
        wait_idle(100);
        chk("run_single_dut0", 32'(g_mon[0].last_run), 13);
        chk("run_single_dut1", 32'(g_mon[1].last_run), 13);

        // Three back-to-back words
        write_word(16'h1234, 1'b1);
        write_word(16'hFFFF, 1'b1);
        write_word(16'h0001, 1'b1);
        wait_idle(200);
        chk("run_burst_dut0", 32'(g_mon[0].last_run), 23);
        chk("run_burst_dut1", 32'(g_mon[1].last_run), 39);

        // Fill with ENABLE low, 17th write dropped
        ENABLE = 1'b0;
        for (int i = 0; i < 17; i++) begin
            write_word(16'(i * 16'h1111) ^ 16'h0F0F, i < 16);
            chk($sformatf("full_after_wr%0d", i), 32'(full), (i >= 15) ? 32'd3 : 32'd0);
            if (i == 15) chk("ovf_before_drop", 32'(ovf), 0);
        end
        chk("ovf_after_drop", 32'(ovf), 3);
        s0 = g_mon[0].words_started;
        s1 = g_mon[1].words_started;
        ENABLE = 1'b1;
        wait_idle(1000);
        chk("frames_after_fill_dut0", 32'(g_mon[0].words_started - s0), 16);
        chk("frames_after_fill_dut1", 32'(g_mon[1].words_started - s1), 16);
        chk("ovf_sticky", 32'(ovf), 3);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);

        // Reset in the second payload cycle
        write_word(16'h3C3C, 1'b1);
        write_word(16'h9999, 1'b1);
        repeat (9) tick();
        RST = 1'b1;
        #1;
        chk("abort_dato", 32'(dato), 0);
        chk("abort_frm", 32'(frm), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_full", 32'(full), 0);
        @(negedge CLK);
        g_mon[0].exp_words.delete();
        g_mon[1].exp_words.delete();
        f0 = g_mon[0].frm_cycles;
        f1 = g_mon[1].frm_cycles;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (40) tick();
        chk("no_resume_dut0", 32'(g_mon[0].frm_cycles - f0), 0);
        chk("no_resume_dut1", 32'(g_mon[1].frm_cycles - f1), 0);
        chk("no_resume_busy", 32'(busy), 0);

        // ENABLE dropped during SYNC with two words queued
        ENABLE = 1'b1;
        write_word(16'h5AA5, 1'b1);
        write_word(16'hC001, 1'b1);
        ENABLE = 1'b0;
        repeat (20) tick();
        chk("hold_busy", 32'(busy), 3);
        chk("hold_frm", 32'(frm), 0);
        chk("hold_left_dut0", 32'(g_mon[0].exp_words.size()), 1);
        chk("hold_left_dut1", 32'(g_mon[1].exp_words.size()), 1);
        chk("hold_run_dut1", 32'(g_mon[1].last_run), 13);
        ENABLE = 1'b1;
        wait_idle(200);

        // Write while full coinciding with a pop
        ENABLE = 1'b0;
        for (int i = 0; i < 16; i++) write_word(16'($urandom), 1'b1);
        chk("full_before_pop", 32'(full), 3);
        chk("ovf_before_pop", 32'(ovf), 0);
        ENABLE = 1'b1;
        repeat (8) tick();
        write_word(16'hDEAD, 1'b0);
        chk("ovf_on_pop_drop", 32'(ovf), 3);
        chk("full_after_pop", 32'(full), 0);
        wait_idle(1000);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;

        // Randomized traffic with random ENABLE gating
        for (int it = 0; it < 400; it++) begin
            ENABLE = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0 && g_mon[0].exp_words.size() < 12 && g_mon[1].exp_words.size() < 12) begin
                chk("rand_not_full", 32'(full), 0);
                write_word(16'($urandom), 1'b1);
            end else begin
                tick();
            end
        end
        ENABLE = 1'b1;
        wait_idle(2000);
        chk("drained_dut0", 32'(g_mon[0].exp_words.size()), 0);
        chk("drained_dut1", 32'(g_mon[1].exp_words.size()), 0);
        chk("final_ovf", 32'(ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
